// File: rtl/cnn_frame_sequencer.sv
// Frame sequencer: clears the CNN, streams one image from memory, waits for its decision.
// Optional DRAIN timeout with error flag when CNN_SEQ_TIMEOUT_EN is defined.
module cnn_frame_sequencer #(
    parameter int NUM_PIXELS = 784,
    parameter int ADDR_W     = 10,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 8192
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rd_data,
    output logic [31:0]       pix_data,
    output logic              pix_valid,
    output logic              cnn_clr,
    input  logic              cnn_valid,
    input  logic [3:0]        cnn_decision,
    output logic [3:0]        result,
    output logic              result_valid,
    output logic              done,
    output logic              error
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLEAR  = 3'd1;
    localparam logic [2:0] STREAM = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam int CLR_W = $clog2(CLR_CYCLES + 1);
    localparam logic [CLR_W-1:0] CLR_LAST =
        CLR_W'(CLR_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR =
        ADDR_W'(NUM_PIXELS - 1);

    logic [2:0]        state;
    logic [2:0]        state_d;
    logic [CLR_W-1:0]  clr_cnt;
    logic [ADDR_W-1:0] addr_cnt;
    logic              timeout_hit;
    logic              kill;

    assign kill = abort && (state != IDLE);

`ifdef CNN_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] drain_cnt;

    assign timeout_hit = (state == DRAIN) && !cnn_valid &&
                         (drain_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_cnt <= '0;
        end else if (state == DRAIN && state_d == DRAIN) begin
            drain_cnt <= drain_cnt + 1'b1;
        end else begin
            drain_cnt <= '0;
        end
    end

    // Sticky until the next accepted start; abort wins over a timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            error <= 1'b0;
        end else if (state == IDLE && start) begin
            error <= 1'b0;
        end else if (!kill && timeout_hit) begin
            error <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
`endif

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (start) state_d = CLEAR;
            end
            CLEAR: begin
                if (abort) state_d = IDLE;
                else if (clr_cnt == CLR_LAST) state_d = STREAM;
            end
            STREAM: begin
                if (abort) state_d = IDLE;
                else if (addr_cnt == LAST_ADDR) state_d = DRAIN;
            end
            DRAIN: begin
                if (abort) state_d = IDLE;
                else if (cnn_valid) state_d = DONE;
                else if (timeout_hit) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_cnt <= '0;
        end else if (state == CLEAR && state_d == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end else begin
            clr_cnt <= '0;
        end
    end

    // Counter is held at zero outside STREAM so mem_addr idles at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_cnt <= '0;
        end else if (state == STREAM && state_d == STREAM) begin
            addr_cnt <= addr_cnt + 1'b1;
        end else begin
            addr_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_valid <= 1'b0;
        end else begin
            pix_valid <= mem_rd_en;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result       <= '0;
            result_valid <= 1'b0;
        end else if (state == IDLE && start) begin
            result_valid <= 1'b0;
        end else if (kill) begin
            result_valid <= 1'b0;
        end else if (state == DRAIN && cnn_valid) begin
            result       <= cnn_decision;
            result_valid <= 1'b1;
        end
    end

    assign busy      = (state != IDLE);
    assign mem_rd_en = (state == STREAM);
    assign mem_addr  = addr_cnt;
    assign cnn_clr   = (state == IDLE) || (state == CLEAR);
    assign done      = (state == DONE);
    assign pix_data  = mem_rd_data;

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Scoreboard bench for cnn_frame_sequencer: expected address, pixel and
// completion events are queued by stimulus and popped by negedge monitors.
module tb_cnn_frame_sequencer;

    localparam int NP  = 784;
    localparam int AW  = 10;
    localparam int CLR = 2;
`ifdef CNN_SEQ_TIMEOUT_EN
    localparam int TO  = 16;
    localparam int NOM_VC = 797;
`else
    localparam int TO  = 8192;
    localparam int NOM_VC = 900;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rd_data = '0;
    logic [31:0]   pix_data;
    logic          pix_valid;
    logic          cnn_clr;
    logic          cnn_valid = 1'b0;
    logic [3:0]    cnn_decision = '0;
    logic [3:0]    result;
    logic          result_valid;
    logic          done;
    logic          error;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    int qa_c[$];
    int qa_v[$];
    int qp_c[$];
    int qp_v[$];
    int qd_c[$];
    int qd_r[$];
    int qd_rv[$];
    int qd_e[$];

    cnn_frame_sequencer #(
        .NUM_PIXELS (NP),
        .ADDR_W     (AW),
        .CLR_CYCLES (CLR),
        .TIMEOUT    (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .cnn_clr      (cnn_clr),
        .cnn_valid    (cnn_valid),
        .cnn_decision (cnn_decision),
        .result       (result),
        .result_valid (result_valid),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(int a);
        return 32'h5A5A_0000 + 32'(a) * 32'd7;
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= pat(int'(mem_addr));
    end

    task automatic chk(string nm, logic [63:0] act,
                       logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst && mem_rd_en) begin
            if (qa_c.size() == 0) begin
                chk("addr_unexpected", 1, 0);
            end else begin
                chk("addr_cycle", cyc, qa_c.pop_front());
                chk("mem_addr", mem_addr, qa_v.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst && pix_valid) begin
            if (qp_c.size() == 0) begin
                chk("pix_unexpected", 1, 0);
            end else begin
                chk("pix_cycle", cyc, qp_c.pop_front());
                chk("pix_data", pix_data, qp_v.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst && done) begin
            if (qd_c.size() == 0) begin
                chk("done_unexpected", 1, 0);
            end else begin
                chk("done_cycle", cyc, qd_c.pop_front());
                chk("result", result, qd_r.pop_front());
                chk("result_valid", result_valid, qd_rv.pop_front());
                chk("error", error, qd_e.pop_front());
                chk("busy_in_done", busy, 1);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto(int c);
        if (c > cyc) tick(c - cyc);
    endtask

    task automatic do_start(output int s);
        start = 1'b1;
        s = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic push_frame(int s, int na, int np);
        for (int i = 0; i < na; i++) begin
            qa_c.push_back(s + CLR + 1 + i);
            qa_v.push_back(i);
        end
        for (int i = 0; i < np; i++) begin
            qp_c.push_back(s + CLR + 2 + i);
            qp_v.push_back(int'(pat(i)));
        end
    endtask

    task automatic push_done(int c, int r, int rv, int e);
        qd_c.push_back(c);
        qd_r.push_back(r);
        qd_rv.push_back(rv);
        qd_e.push_back(e);
    endtask

    task automatic pulse_valid(int d);
        cnn_valid = 1'b1;
        cnn_decision = 4'(d);
        tick(1);
        cnn_valid = 1'b0;
    endtask

    task automatic chk_reset_outs(string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rd_en"}, mem_rd_en, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_pix_valid"}, pix_valid, 0);
        chk({tag, "_cnn_clr"}, cnn_clr, 1);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    initial begin
        #(10 * 50000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int lc;
        tick(3);
        chk_reset_outs("rst");
        rst = 1'b1;
        tick(2);

        // Nominal frame, ignored start and early cnn_valid.
        do_start(s);
        push_frame(s, NP, NP);
        push_done(s + NOM_VC + 1, 7, 1, 0);
        chk("nom_busy", busy, 1);
        chk("nom_clr_clear", cnn_clr, 1);
        goto(s + CLR);
        chk("nom_rd_en_pre", mem_rd_en, 0);
        goto(s + CLR + 1);
        chk("nom_clr_stream", cnn_clr, 0);
        goto(s + 100);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        goto(s + 200);
        pulse_valid(3);
        goto(s + NOM_VC - 5);
        chk("nom_drain_busy", busy, 1);
        chk("nom_drain_rv", result_valid, 0);
        goto(s + NOM_VC);
        pulse_valid(7);
        goto(s + NOM_VC + 2);
        chk("nom_idle_busy", busy, 0);
        tick(5);
        chk("nom_hold_result", result, 7);
        chk("nom_hold_rv", result_valid, 1);

        // Abort in STREAM at address 300.
        do_start(s);
        chk("abt_start_clr_rv", result_valid, 0);
        chk("abt_start_result", result, 7);
        push_frame(s, 301, 301);
        goto(s + CLR + 1 + 300);
        chk("abt_addr300", mem_addr, 300);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abt_rd_en", mem_rd_en, 0);
        chk("abt_cnn_clr", cnn_clr, 1);
        chk("abt_busy", busy, 0);
        chk("abt_rv", result_valid, 0);
        tick(3);

        // Frame giving result 5.
        do_start(s);
        push_frame(s, NP, NP);
        lc = s + CLR + 1 + NP + 5;
        push_done(lc + 1, 5, 1, 0);
        goto(lc);
        pulse_valid(5);
        tick(3);

        // Abort and cnn_valid in the same DRAIN cycle.
        do_start(s);
        push_frame(s, NP, NP);
        goto(s + CLR + 1 + NP + 10);
        abort = 1'b1;
        cnn_valid = 1'b1;
        cnn_decision = 4'd9;
        tick(1);
        abort = 1'b0;
        cnn_valid = 1'b0;
        chk("ab_cv_busy", busy, 0);
        chk("ab_cv_result", result, 5);
        chk("ab_cv_rv", result_valid, 0);
        tick(3);

`ifdef CNN_SEQ_TIMEOUT_EN
        do_start(s);
        push_frame(s, NP, NP);
        lc = s + CLR + 1 + NP + TO;
        push_done(lc, 5, 0, 1);
        goto(lc + 3);
        chk("to_err_sticky", error, 1);
        chk("to_busy", busy, 0);
        do_start(s);
        chk("to_start_clr_err", error, 0);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("to_abort_busy", busy, 0);
        tick(3);
`else
        do_start(s);
        push_frame(s, NP, NP);
        lc = s + CLR + 1 + NP + 300;
        goto(lc);
        chk("wait_busy", busy, 1);
        chk("wait_error", error, 0);
        push_done(lc + 1, 2, 1, 0);
        pulse_valid(2);
        tick(3);
`endif

        // Reset mid-stream at address 50.
        do_start(s);
        push_frame(s, 50, 49);
        goto(s + CLR + 1 + 50);
        chk("mid_addr50", mem_addr, 50);
        rst = 1'b0;
        #1;
        chk_reset_outs("mid");
        tick(2);
        rst = 1'b1;
        tick(2);
        do_start(s);
        push_frame(s, NP, NP);
        lc = s + CLR + 1 + NP + 10;
        push_done(lc + 1, 4, 1, 0);
        goto(lc);
        pulse_valid(4);
        tick(5);

        chk("left_addr", qa_c.size(), 0);
        chk("left_pix", qp_c.size(), 0);
        chk("left_done", qd_c.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cnn_frame_sequencer.md
CNN_FRAME_SEQUENCER -- requirements
Module: cnn_frame_sequencer

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 784, pixels per frame.
REQ-002 SHALL have parameter ADDR_W, default 10, image-memory address width; 2**ADDR_W >= NUM_PIXELS.
REQ-003 SHALL have parameter CLR_CYCLES, default 2, datapath-clear duration in cycles; minimum 1.
REQ-004 SHALL have parameter TIMEOUT, default 8192, maximum DRAIN cycles before error.
REQ-005 SHALL have port clk, input, 1 bit, the single clock.
REQ-006 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1 bit, frame request pulse.
REQ-008 SHALL have port abort, input, 1 bit, cancel the current frame.
REQ-009 SHALL have port busy, output, 1 bit, high when state is not IDLE.
REQ-010 SHALL have ports mem_rd_en, output, 1 bit, and mem_addr, output, ADDR_W bits, image-memory read request.
REQ-011 SHALL have port mem_rd_data, input, 32 bits, read data, valid one cycle after mem_rd_en.
REQ-012 SHALL have ports pix_data, output, 32 bits, and pix_valid, output, 1 bit, pixel stream to in_data_unquant.
REQ-013 SHALL have port cnn_clr, output, 1 bit, synchronous clear to the CNN datapath.
REQ-014 SHALL have ports cnn_valid, input, 1 bit, and cnn_decision, input, 4 bits, the CNN classification result.
REQ-015 SHALL have ports result, output, 4 bits; result_valid, output, 1 bit; done, output, 1 bit; error, output, 1 bit.

Function
REQ-016 SHALL implement FSM states IDLE, CLEAR, STREAM, DRAIN, DONE.
REQ-017 IDLE: cnn_clr=1; start moves to CLEAR and clears result_valid and error; start is ignored in every other state.
REQ-018 CLEAR: cnn_clr=1 for exactly CLR_CYCLES cycles, then STREAM.
REQ-019 STREAM: cnn_clr=0; mem_rd_en=1 each cycle; mem_addr counts 0..NUM_PIXELS-1, one per cycle; after the last address, go to DRAIN.
REQ-020 pix_valid SHALL equal mem_rd_en delayed one cycle; pix_data SHALL equal mem_rd_data unregistered.
REQ-021 Timing: with start in cycle 0, mem_rd_en is first high in cycle CLR_CYCLES+1 and the last pix_valid is in cycle CLR_CYCLES+NUM_PIXELS+1.
REQ-022 cnn_valid outside DRAIN SHALL be ignored.
REQ-023 DRAIN: the first cnn_valid latches cnn_decision into result, sets result_valid=1, and moves to DONE.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE.
REQ-025 result and result_valid SHALL hold until the next accepted start.
REQ-026 abort in any non-IDLE state SHALL force IDLE on the next clock with no done pulse and result_valid=0.
REQ-027 abort SHALL take priority over cnn_valid, timeout, and address terminal count in the same cycle.
REQ-028 busy SHALL be registered-state derived: busy=1 from the cycle after an accepted start through the DONE cycle.

Reset
REQ-029 On rst low, the FSM SHALL go to IDLE asynchronously.
REQ-030 On rst low, all counters SHALL clear to 0.
REQ-031 During reset: mem_rd_en=0, mem_addr=0, pix_valid=0, cnn_clr=1, result=0, result_valid=0, done=0, error=0, busy=0.
REQ-032 Reset asserted mid-frame SHALL discard the frame; no done pulse SHALL be generated.

Configuration
REQ-033 Macro CNN_SEQ_TIMEOUT_EN defined: a DRAIN cycle counter SHALL run; if TIMEOUT cycles elapse without cnn_valid, the block SHALL set error=1 (sticky until next start), keep result_valid=0, and go to DONE (done pulses).
REQ-034 Macro CNN_SEQ_TIMEOUT_EN undefined: no counter SHALL be built; error SHALL be tied to 0; DRAIN waits indefinitely.

Verification
REQ-035 Nominal: CLR_CYCLES=2, start in cycle 0, cnn_valid with cnn_decision=7 at cycle 900 -> addresses 0..783 in cycles 3..786, pix_valid in 4..787, result=7, result_valid=1, done pulse in cycle 901.
REQ-036 Busy start: second start at cycle 100 -> ignored; mem_addr sequence uninterrupted; exactly one done.
REQ-037 Abort at mem_addr=300 -> IDLE next cycle, mem_rd_en=0, cnn_clr=1, no done, result_valid=0.
REQ-038 Abort and cnn_valid in the same DRAIN cycle -> IDLE, no done, result unchanged.
REQ-039 CNN_SEQ_TIMEOUT_EN defined, TIMEOUT=16, no cnn_valid -> error=1 and done pulse 16 cycles after entering DRAIN; next start clears error.
REQ-040 rst low during STREAM at mem_addr=50 -> all outputs at reset values immediately; after release, start yields a full 784-pixel stream from address 0.
